alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 119 +++++++++++
 tb/tb_alu_pipe.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshake on both sides.
//   S1 registers the operands and opcode; S2 computes and registers result,
//   flags and illegal. Both stages advance together whenever the output slot
//   is empty or being drained (adv), so in_ready is purely a function of the
//   output side.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready == adv)
//   a, b [WIDTH]          operands
//   op [3]                0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL1, 6 SHR1, 7 ADDS
//   out_valid / out_ready result handshake
//   result [WIDTH]        registered result
//   flags [4]             registered {ovf, neg, zero, carry}
//   illegal               registered; result came from a disabled opcode
//
// Configuration
//   ALU_PIPE_SAT_EN       when defined, op 7 is an unsigned saturating add;
//                         otherwise op 7 yields zero result and raises illegal.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             illegal
);

  localparam int STAGES = 2;
  localparam int MSB    = WIDTH - 1;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
  } req_t;

  logic [STAGES:1] vld_pipe;  // [1] = S1 valid, [2] = S2 valid (out_valid)
  req_t            s1;
  logic            adv;

  assign adv       = !vld_pipe[STAGES] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[STAGES];

  // S2 next-state logic, computed from the S1 registers.
  logic [WIDTH:0]   sum, dif;
  logic [WIDTH-1:0] nres;
  logic             ncarry, novf, nill;

  always_comb begin
    // One extra bit catches carry-out of the add and borrow of the subtract.
    sum    = {1'b0, s1.a} + {1'b0, s1.b};
    dif    = {1'b0, s1.a} - {1'b0, s1.b};
    nres   = '0;
    ncarry = 1'b0;
    novf   = 1'b0;
    nill   = 1'b0;
    case (s1.op)
      3'd0: begin
        nres   = sum[WIDTH-1:0];
        ncarry = sum[WIDTH];
        // Like-signed operands producing an opposite-signed sum.
        novf   = (s1.a[MSB] == s1.b[MSB]) && (sum[MSB] != s1.a[MSB]);
      end
      3'd1: begin
        nres   = dif[WIDTH-1:0];
        ncarry = dif[WIDTH];  // borrow: set iff a < b unsigned
        // Unlike-signed operands where the difference takes b's sign.
        novf   = (s1.a[MSB] != s1.b[MSB]) && (dif[MSB] != s1.a[MSB]);
      end
      3'd2: nres = s1.a & s1.b;
      3'd3: nres = s1.a | s1.b;
      3'd4: nres = s1.a ^ s1.b;
      3'd5: begin
        nres   = {s1.a[WIDTH-2:0], 1'b0};
        ncarry = s1.a[MSB];
      end
      3'd6: begin
        nres   = {1'b0, s1.a[WIDTH-1:1]};
        ncarry = s1.a[0];
      end
      default: begin
`ifdef ALU_PIPE_SAT_EN
        nres   = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
        ncarry = sum[WIDTH];
`else
        nill   = 1'b1;  // result stays 0, so only the zero flag is raised
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1       <= '0;
      result   <= '0;
      flags    <= '0;
      illegal  <= 1'b0;
    end else if (adv) begin
      // Bubbles shift through as invalid slots; they are never collapsed.
      vld_pipe <= {vld_pipe[1], in_valid};
      s1       <= '{a: a, b: b, op: op};
      result   <= nres;
      flags    <= {novf, nres[MSB], (nres == '0), ncarry};
      illegal  <= nill;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: expected results are modelled and queued
// when an operand transfer is seen, then popped when the result transfers.
// A second 16-bit instance covers the wide shift cases.
module tb_alu_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, illegal;
  logic [7:0] a, b, result;
  logic [2:0] op;
  logic [3:0] flags;

  logic        in_valid16, in_ready16, out_valid16, out_ready16, illegal16;
  logic [15:0] a16, b16, result16;
  logic [2:0]  op16;
  logic [3:0]  flags16;

  alu_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .illegal(illegal)
  );

  alu_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .op(op16), .out_valid(out_valid16), .out_ready(out_ready16),
    .result(result16), .flags(flags16), .illegal(illegal16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] res;
    logic [3:0] flg;
    logic       ill;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   npush = 0;
  int   npop  = 0;
  int   run   = 0;
  int   max_run = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model written with plain integer arithmetic.
  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic [2:0] o);
    exp_t e;
    int   ux, uy, sx, sy, s;
    logic c, v;
    ux = int'(x); uy = int'(y);
    sx = (ux > 127) ? ux - 256 : ux;
    sy = (uy > 127) ? uy - 256 : uy;
    c = 1'b0; v = 1'b0; e.ill = 1'b0; s = 0;
    case (o)
      3'd0: begin s = ux + uy; c = (s > 255); v = ((sx + sy) > 127) || ((sx + sy) < -128); end
      3'd1: begin s = ux - uy; c = (ux < uy); v = ((sx - sy) > 127) || ((sx - sy) < -128); end
      3'd2: s = int'(x & y);
      3'd3: s = int'(x | y);
      3'd4: s = int'(x ^ y);
      3'd5: begin s = ux * 2; c = x[7]; end
      3'd6: begin s = ux / 2; c = x[0]; end
      default: begin
`ifdef ALU_PIPE_SAT_EN
        s = ux + uy;
        c = (s > 255);
        if (c) s = 255;
`else
        s = 0;
        e.ill = 1'b1;
`endif
      end
    endcase
    e.res = 8'(s);
    e.flg = {v, e.res[7], (e.res == 8'h00), c};
    return e;
  endfunction

  // Monitor: decide transfers on the falling edge, where handshake signals are settled.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      if (in_valid && in_ready) begin
        sb.push_back(model(a, b, op));
        npush++;
      end
      run = out_valid ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = sb.pop_front();
          chk("result", result, e.res);
          chk("flags", flags, e.flg);
          chk("illegal", illegal, e.ill);
          npop++;
        end
      end
    end
  end

  task automatic send(input logic [7:0] xa, input logic [7:0] xb, input logic [2:0] xop);
    int n;
    a = xa; b = xb; op = xop; in_valid = 1'b1;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send16(input logic [15:0] xa, input logic [2:0] xop,
                        input logic [15:0] er, input logic [3:0] ef);
    int n;
    a16 = xa; b16 = 16'($urandom); op16 = xop; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    n = 0;
    while (!out_valid16 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) chk("w16_timeout", 0, 1);
    chk("w16_result", result16, er);
    chk("w16_flags", flags16, ef);
    chk("w16_illegal", illegal16, 0);
    @(posedge clk); #1;
  endtask

  bit rnd_done;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
    in_valid16 = 1'b0; out_ready16 = 1'b1; a16 = '0; b16 = '0; op16 = '0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", flags, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // 0xFF + 0x01: result visible two cycles after the operands are presented.
    send(8'hFF, 8'h01, 3'd0);
    chk("lat_s1_only", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_out_valid", out_valid, 1);
    chk("add_wrap_res", result, 8'h00);
    chk("add_wrap_flags", flags, 4'b0011);
    idle(2);

    send(8'h80, 8'h01, 3'd1);   // signed overflow, no borrow
    send(8'h01, 8'h02, 3'd1);   // borrow, negative
    send(8'hF0, 8'h20, 3'd7);   // ADDS: saturates or is illegal
    send(8'hC3, 8'h5A, 3'd2);
    send(8'hC3, 8'h5A, 3'd3);
    send(8'hC3, 8'h5A, 3'd4);
    send(8'h81, 8'hFF, 3'd5);
    send(8'h81, 8'hFF, 3'd6);
    send(8'h10, 8'h20, 3'd7);   // ADDS without saturation
    send(8'h7F, 8'h01, 3'd0);   // positive overflow
    idle(4);

    // Back-to-back stream of ten ADDs.
    max_run = 0;
    for (int i = 0; i < 10; i++) send(8'(i * 17), 8'(i + 3), 3'd0);
    idle(4);
    chk("stream_run", max_run, 10);

    // Stall with two results in flight.
    send(8'h12, 8'h34, 3'd0);
    send(8'h56, 8'h78, 3'd1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_result", result, sb.size() > 0 ? sb[0].res : 8'hxx);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle(4);
    chk("stall_drained", sb.size(), 0);
    chk("stall_no_loss", npop, npush);

    // Random traffic with random backpressure.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++)
          send(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    idle(5);
    chk("rnd_drained", sb.size(), 0);
    chk("rnd_no_loss", npop, npush);

    // Reset with two transactions in flight.
    send(8'h11, 8'h22, 3'd0);
    send(8'h33, 8'h44, 3'd4);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_result", result, 0);
    idle(2);
    rst_n = 1'b1;
    max_run = 0;
    run = 0;
    idle(4);
    chk("midrst_no_stale", max_run, 0);
    send(8'h05, 8'h03, 3'd1);
    idle(3);
    chk("post_rst_drained", sb.size(), 0);

    // Wide instance: shifts ignore b.
    send16(16'h8001, 3'd5, 16'h0002, 4'b0001);
    send16(16'h8001, 3'd6, 16'h4000, 4'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", total, 0);
    $fatal(1, "timeout");
  end

endmodule
